// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: reset/bubble constants, instruction
// field positions and the fetch FSM state encoding.
package cpu_pkg;

    localparam logic [31:0] CPU_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;

    // RUN: normal fetch; REDIR: redirect accepted during a miss, waiting for it to finish
    localparam logic [0:0] FS_RUN   = 1'b0;
    localparam logic [0:0] FS_REDIR = 1'b1;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: write enable, flush to bubble, asynchronous reset.
// Flush wins over write enable; PC4 holds on flush since a bubble's PC4 is don't-care.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic        flush_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc4_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc4_q, pc4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    always_comb begin
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (we_i) begin
            pc4_d   = pc4_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc4_q   <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction fetch: PC, next-PC selection, miss/redirect FSM and IF/ID register.
// Define IF_PERF_CNT_EN to add the perf_fetched/perf_miss_cycles/perf_flushes counters.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
    parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic [31:0] ICACHE_rdata,
    input  logic        ICACHE_stall,
    output logic        fetch_stall,
    output logic [31:0] IFID_PC4,
    output logic [31:0] IFID_instr,
    output logic        IFID_valid,
    output logic [5:0]  IFID_opcode,
    output logic [4:0]  IFID_Rs,
    output logic [4:0]  IFID_Rt,
    output logic [0:0]  fetch_state_dbg
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_miss_cycles,
    output logic [31:0] perf_flushes
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [0:0]  state_q, state_d;

    logic        redirect_req;
    logic [31:0] sel_target;
    logic [31:0] pc_plus4;
    logic        ifid_we;
    logic        ifid_flush;

    // A redirect with PCWrite=0 is dropped: branch operands are stale during a load-use stall
    assign redirect_req = PCWrite & (branch_taken | jump);
    assign sel_target   = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
    assign pc_plus4     = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        if (state_q == FS_REDIR) begin
            // The outstanding miss always completes; its data is discarded
            if (!ICACHE_stall) begin
                pc_d       = tgt_q;
                ifid_flush = 1'b1;
                state_d    = FS_RUN;
            end
        end else if (ICACHE_stall) begin
            if (redirect_req) begin
                tgt_d   = sel_target;
                state_d = FS_REDIR;
            end
        end else if (redirect_req) begin
            pc_d       = sel_target;
            ifid_flush = 1'b1;
        end else begin
            if (PCWrite) begin
                pc_d = pc_plus4;
            end
            ifid_we = IFIDWrite;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            tgt_q   <= 32'h0000_0000;
            state_q <= FS_RUN;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            state_q <= state_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ifid_we),
        .flush_i (ifid_flush),
        .pc4_i   (pc_plus4),
        .instr_i (ICACHE_rdata),
        .pc4_o   (IFID_PC4),
        .instr_o (IFID_instr),
        .valid_o (IFID_valid)
    );

    assign ICACHE_ren      = rst_n;
    assign ICACHE_addr     = pc_q[31:2];
    assign fetch_stall     = ICACHE_stall;
    assign IFID_opcode     = IFID_instr[OPCODE_MSB:OPCODE_LSB];
    assign IFID_Rs         = IFID_instr[RS_MSB:RS_LSB];
    assign IFID_Rt         = IFID_instr[RT_MSB:RT_LSB];
    assign fetch_state_dbg = state_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetched_q, miss_q, flushes_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= 32'h0000_0000;
            miss_q    <= 32'h0000_0000;
            flushes_q <= 32'h0000_0000;
        end else begin
            fetched_q <= fetched_q + {31'd0, ifid_we};
            miss_q    <= miss_q + {31'd0, ICACHE_stall};
            flushes_q <= flushes_q + {31'd0, ifid_flush};
        end
    end

    assign perf_fetched     = fetched_q;
    assign perf_miss_cycles = miss_q;
    assign perf_flushes     = flushes_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a cycle-level behavioural model checked every
// cycle on the falling edge, plus hand-computed literal expectations.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        ifid_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        icache_ren;
    logic [29:0] icache_addr;
    logic [31:0] icache_rdata;
    logic        icache_stall;
    logic        fetch_stall;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [5:0]  ifid_opcode;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic [0:0]  fetch_state_dbg;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_miss_cycles;
    logic [31:0] perf_flushes;
`endif

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .PCWrite         (pc_write),
        .IFIDWrite       (ifid_write),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .ICACHE_ren      (icache_ren),
        .ICACHE_addr     (icache_addr),
        .ICACHE_rdata    (icache_rdata),
        .ICACHE_stall    (icache_stall),
        .fetch_stall     (fetch_stall),
        .IFID_PC4        (ifid_pc4),
        .IFID_instr      (ifid_instr),
        .IFID_valid      (ifid_valid),
        .IFID_opcode     (ifid_opcode),
        .IFID_Rs         (ifid_rs),
        .IFID_Rt         (ifid_rt),
        .fetch_state_dbg (fetch_state_dbg)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_miss_cycles (perf_miss_cycles),
        .perf_flushes     (perf_flushes)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- instruction memory ----------------
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        logic [31:0] w;
        w = {2'b00, a} * 32'h9E37_79B1;
        return w ^ 32'h1357_9BDF;
    endfunction

    // During a miss the cache drives junk that must never be captured
    assign icache_rdata = icache_stall ? 32'hDEAD_BEEF : mem_word(icache_addr);

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc        = 32'h0;
    logic        m_pend      = 1'b0;
    logic [31:0] m_pend_tgt  = 32'h0;
    logic [31:0] m_pc4       = 32'h0;
    logic        m_pc4_known = 1'b1;
    logic [31:0] m_instr     = 32'h0;
    logic        m_valid     = 1'b0;
    int unsigned m_fetched   = 0;
    int unsigned m_misses    = 0;
    int unsigned m_flushes   = 0;

    task automatic model_bubble();
        m_instr     = 32'h0;
        m_valid     = 1'b0;
        m_pc4_known = 1'b0;
        m_flushes++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_pend = 1'b0; m_pend_tgt = 32'h0;
            m_pc4 = 32'h0; m_pc4_known = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
            m_fetched = 0; m_misses = 0; m_flushes = 0;
        end else if (icache_stall) begin
            m_misses++;
            if (!m_pend && pc_write && (branch_taken || jump)) begin
                m_pend     = 1'b1;
                m_pend_tgt = (branch_taken ? branch_target : jump_target) & ~32'h3;
            end
        end else if (m_pend) begin
            m_pc   = m_pend_tgt;
            m_pend = 1'b0;
            model_bubble();
        end else if (pc_write && (branch_taken || jump)) begin
            m_pc = (branch_taken ? branch_target : jump_target) & ~32'h3;
            model_bubble();
        end else begin
            if (ifid_write) begin
                m_pc4       = m_pc + 32'd4;
                m_pc4_known = 1'b1;
                m_instr     = mem_word(m_pc[31:2]);
                m_valid     = 1'b1;
                m_fetched++;
            end
            if (pc_write) m_pc = m_pc + 32'd4;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ren", {31'd0, icache_ren}, {31'd0, rst_n});
        chk("addr", {2'b00, icache_addr}, {2'b00, m_pc[31:2]});
        chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, icache_stall});
        chk("valid", {31'd0, ifid_valid}, {31'd0, m_valid});
        chk("instr", ifid_instr, m_instr);
        chk("opcode", {26'd0, ifid_opcode}, {26'd0, m_instr[31:26]});
        chk("rs", {27'd0, ifid_rs}, {27'd0, m_instr[25:21]});
        chk("rt", {27'd0, ifid_rt}, {27'd0, m_instr[20:16]});
        chk("state", {31'd0, fetch_state_dbg}, {31'd0, m_pend});
        if (m_pc4_known) chk("pc4", ifid_pc4, m_pc4);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_miss", perf_miss_cycles, m_misses);
        chk("perf_flushes", perf_flushes, m_flushes);
`endif
    end

    // ---------------- driver ----------------
    task automatic drive(input logic pcw, input logic ifw, input logic bt, input logic [31:0] bta,
                         input logic j, input logic [31:0] jt, input logic st);
        pc_write      = pcw;
        ifid_write    = ifw;
        branch_taken  = bt;
        branch_target = bta;
        jump          = j;
        jump_target   = jt;
        icache_stall  = st;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic st);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, st);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        pc_write = 1'b0; ifid_write = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0; icache_stall = 1'b0;
        #1;
        chk("rst_ren", {31'd0, icache_ren}, 32'd0);
        chk("rst_addr", {2'b00, icache_addr}, 32'd0);
        chk("rst_pc4", ifid_pc4, 32'd0);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ren", {31'd0, icache_ren}, 32'd1);

        // sequential hits
        run(1'b0); chk("seq_addr1", {2'b00, icache_addr}, 32'd1); chk("seq_pc4_1", ifid_pc4, 32'd4);
        run(1'b0); chk("seq_addr2", {2'b00, icache_addr}, 32'd2); chk("seq_pc4_2", ifid_pc4, 32'd8);
        run(1'b0); chk("seq_addr3", {2'b00, icache_addr}, 32'd3); chk("seq_pc4_3", ifid_pc4, 32'd12);
        chk("seq_valid", {31'd0, ifid_valid}, 32'd1);
        chk("seq_instr", ifid_instr, mem_word(30'd2));
        run(1'b0); chk("seq_addr4", {2'b00, icache_addr}, 32'd4);

        // hazard hold at PC=0x10
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("hold_addr", {2'b00, icache_addr}, 32'h4);
        chk("hold_pc4", ifid_pc4, 32'h10);
        run(1'b0);
        chk("resume_addr", {2'b00, icache_addr}, 32'h5);
        chk("resume_pc4", ifid_pc4, 32'h14);

        // branch on a hit
        drive(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        chk("br_addr", {2'b00, icache_addr}, 32'h40);
        chk("br_valid", {31'd0, ifid_valid}, 32'd0);
        chk("br_instr", ifid_instr, 32'h0);
        run(1'b0);
        chk("br_next_pc4", ifid_pc4, 32'h104);

        // jump during a 5-cycle miss; a second redirect mid-miss is ignored
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
        chk("miss_state", {31'd0, fetch_state_dbg}, 32'd1);
        drive(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
        run(1'b1); run(1'b1); run(1'b1);
        chk("miss_addr_stable", {2'b00, icache_addr}, 32'h41);
        chk("miss_ifid_hold", ifid_pc4, 32'h104);
        run(1'b0);
        chk("redir_addr", {2'b00, icache_addr}, 32'h10);
        chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
        chk("redir_state", {31'd0, fetch_state_dbg}, 32'd0);

        // branch with PCWrite=0 is ignored, IF/ID still written
        drive(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
        chk("nobr_addr", {2'b00, icache_addr}, 32'h10);
        chk("nobr_valid", {31'd0, ifid_valid}, 32'd1);
        chk("nobr_pc4", ifid_pc4, 32'h44);

        // branch wins over jump, low target bits dropped
        drive(1'b1, 1'b1, 1'b1, 32'h203, 1'b1, 32'h500, 1'b0);
        chk("prio_addr", {2'b00, icache_addr}, 32'h80);

        // PC wrap
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("wrap_top", {2'b00, icache_addr}, 32'h3FFF_FFFF);
        run(1'b0);
        chk("wrap_addr", {2'b00, icache_addr}, 32'h0);
        chk("wrap_pc4", ifid_pc4, 32'h0);
        chk("wrap_valid", {31'd0, ifid_valid}, 32'd1);
        run(1'b0);
`ifdef IF_PERF_CNT_EN
        chk("lit_flushes", perf_flushes, 32'd4);
        chk("lit_misses", perf_miss_cycles, 32'd5);
`endif

        // reset in the middle of a redirected miss
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        chk("mid_state", {31'd0, fetch_state_dbg}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ren", {31'd0, icache_ren}, 32'd0);
        chk("mid_rst_state", {31'd0, fetch_state_dbg}, 32'd0);
        chk("mid_rst_addr", {2'b00, icache_addr}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        run(1'b0);
        chk("after_rst_addr", {2'b00, icache_addr}, 32'd1);
        chk("after_rst_pc4", ifid_pc4, 32'd4);
        run(1'b0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
